cdb_arbiter: RTL

- Collects completed results from NUM_FU functional units, buffers them per unit, and broadcasts up to WAYS results per cycle on the Common Data Bus.
- The CDB feeds the reservation station, which wakes up entries by PRF index, and also feeds the PRF and ROB.
- Sits directly upstream of the reservation station's CDB_Data / CDB_PRF_idx / CDB_valid inputs.
- Guarantees CDB_valid is packed LSB-first (0, 1, 11, 111), as the reservation station requires.

---
 rtl/cdb_arbiter_if.sv | 29 ++
 rtl/cdb_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: functional-unit result handshake and Common Data Bus broadcast bundle.
// Shared by the FU side (master) and the arbiter (slave).
interface cdb_arbiter_if #(
  parameter int unsigned WAYS   = 3,
  parameter int unsigned NUM_FU = 4,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PRF    = 64
);
  localparam int unsigned TagW = $clog2(PRF);

  logic                             squash;
  logic [NUM_FU-1:0]                fu_valid;
  logic [NUM_FU-1:0][XLEN-1:0]      fu_data;
  logic [NUM_FU-1:0][TagW-1:0]      fu_prf_idx;
  logic [NUM_FU-1:0]                fu_ready;
  logic [WAYS-1:0][XLEN-1:0]        CDB_Data;
  logic [WAYS-1:0][TagW-1:0]        CDB_PRF_idx;
  logic [WAYS-1:0]                  CDB_valid;

  modport master (
    output squash, fu_valid, fu_data, fu_prf_idx,
    input  fu_ready, CDB_Data, CDB_PRF_idx, CDB_valid
  );

  modport slave (
    input  squash, fu_valid, fu_data, fu_prf_idx,
    output fu_ready, CDB_Data, CDB_PRF_idx, CDB_valid
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers results from NUM_FU functional units in per-source FIFOs and
// broadcasts up to WAYS of them per cycle on the CDB, round-robin, LSB-packed.
// Optional macro CDB_ARB_BYPASS_EN: an empty source's incoming result may be granted
// in the same cycle (1-cycle latency) without being written to its FIFO.
module cdb_arbiter #(
  parameter int unsigned WAYS   = 3,
  parameter int unsigned NUM_FU = 4,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PRF    = 64,
  parameter int unsigned DEPTH  = 2
) (
  input  logic         clock,
  input  logic         reset,
  cdb_arbiter_if.slave bus
);

  localparam int unsigned TagW     = $clog2(PRF);
  localparam int unsigned PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW     = PtrW + 1;
  localparam int unsigned RrW      = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int unsigned SlotIdxW = (WAYS > 1) ? $clog2(WAYS) : 1;

`ifdef CDB_ARB_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  // FIFO storage and bookkeeping
  logic [XLEN-1:0]  r_data  [NUM_FU][DEPTH];
  logic [TagW-1:0]  r_tag   [NUM_FU][DEPTH];
  logic [PtrW-1:0]  r_head  [NUM_FU];
  logic [PtrW-1:0]  r_tail  [NUM_FU];
  logic [CntW-1:0]  r_count [NUM_FU];
  logic [RrW-1:0]   r_rr_ptr;

  // registered CDB outputs
  logic [WAYS-1:0]            r_cdb_valid;
  logic [WAYS-1:0][XLEN-1:0]  r_cdb_data;
  logic [WAYS-1:0][TagW-1:0]  r_cdb_tag;

  logic [NUM_FU-1:0]          w_ready;
  logic [NUM_FU-1:0]          w_accept;
  logic [NUM_FU-1:0]          w_push;
  logic [NUM_FU-1:0]          w_pop;
  logic [NUM_FU-1:0]          w_bypass;
  logic [WAYS-1:0]            w_slot_valid;
  logic [WAYS-1:0][XLEN-1:0]  w_slot_data;
  logic [WAYS-1:0][TagW-1:0]  w_slot_tag;
  logic [RrW-1:0]             w_last_src;
  logic                       w_any_grant;
  logic [RrW-1:0]             w_rr_next;

  // Ready depends only on registered occupancy; a full FIFO refuses even if popped now.
  always_comb begin
    for (int unsigned s = 0; s < NUM_FU; s++) begin
      w_ready[s]  = (r_count[s] != CntW'(DEPTH));
      w_accept[s] = bus.fu_valid[s] & w_ready[s] & ~bus.squash;
      w_push[s]   = w_accept[s] & ~w_bypass[s];
    end
  end

  // Round-robin scan from r_rr_ptr; k-th grant lands in slot k so valids stay LSB-packed.
  always_comb begin : sel_comb
    int unsigned n_sel;
    int unsigned src;
    n_sel        = 0;
    src          = 0;
    w_pop        = '0;
    w_bypass     = '0;
    w_slot_valid = '0;
    w_slot_data  = '0;
    w_slot_tag   = '0;
    w_last_src   = r_rr_ptr;
    w_any_grant  = 1'b0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      src = 32'(r_rr_ptr) + i;
      if (src >= NUM_FU) src = src - NUM_FU;
      if ((n_sel < WAYS) && !bus.squash) begin
        if (r_count[RrW'(src)] != '0) begin
          w_pop[RrW'(src)]                  = 1'b1;
          w_slot_valid[SlotIdxW'(n_sel)]    = 1'b1;
          w_slot_data[SlotIdxW'(n_sel)]     = r_data[RrW'(src)][r_head[RrW'(src)]];
          w_slot_tag[SlotIdxW'(n_sel)]      = r_tag[RrW'(src)][r_head[RrW'(src)]];
          w_last_src                        = RrW'(src);
          w_any_grant                       = 1'b1;
          n_sel                             = n_sel + 1;
        end else if (BypassEn && bus.fu_valid[RrW'(src)] && w_ready[RrW'(src)]) begin
          w_bypass[RrW'(src)]               = 1'b1;
          w_slot_valid[SlotIdxW'(n_sel)]    = 1'b1;
          w_slot_data[SlotIdxW'(n_sel)]     = bus.fu_data[RrW'(src)];
          w_slot_tag[SlotIdxW'(n_sel)]      = bus.fu_prf_idx[RrW'(src)];
          w_last_src                        = RrW'(src);
          w_any_grant                       = 1'b1;
          n_sel                             = n_sel + 1;
        end
      end
    end
  end

  // Next round-robin start: one past the last granted source, wrapping at NUM_FU.
  always_comb begin
    w_rr_next = r_rr_ptr;
    if (w_any_grant) begin
      w_rr_next = (w_last_src == RrW'(NUM_FU - 1)) ? '0 : w_last_src + RrW'(1);
    end
  end

  // FIFO payload write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clock) begin
    for (int unsigned s = 0; s < NUM_FU; s++) begin
      if (w_push[s]) begin
        r_data[s][r_tail[s]] <= bus.fu_data[s];
        r_tag[s][r_tail[s]]  <= bus.fu_prf_idx[s];
      end
    end
  end

  // FIFO pointers and occupancy; squash empties everything.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned s = 0; s < NUM_FU; s++) begin
        r_head[s]  <= '0;
        r_tail[s]  <= '0;
        r_count[s] <= '0;
      end
    end else if (bus.squash) begin
      for (int unsigned s = 0; s < NUM_FU; s++) begin
        r_head[s]  <= '0;
        r_tail[s]  <= '0;
        r_count[s] <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < NUM_FU; s++) begin
        if (w_push[s]) r_tail[s] <= r_tail[s] + PtrW'(1);
        if (w_pop[s])  r_head[s] <= r_head[s] + PtrW'(1);
        if (w_push[s] && !w_pop[s]) begin
          r_count[s] <= r_count[s] + CntW'(1);
        end else if (!w_push[s] && w_pop[s]) begin
          r_count[s] <= r_count[s] - CntW'(1);
        end
      end
    end
  end

  // Round-robin pointer; held across squash.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= '0;
    end else if (!bus.squash) begin
      r_rr_ptr <= w_rr_next;
    end
  end

  // CDB output registers; idle slots keep their last payload, consumers gate on valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cdb_valid <= '0;
      r_cdb_data  <= '0;
      r_cdb_tag   <= '0;
    end else if (bus.squash) begin
      r_cdb_valid <= '0;
    end else begin
      r_cdb_valid <= w_slot_valid;
      for (int unsigned k = 0; k < WAYS; k++) begin
        if (w_slot_valid[k]) begin
          r_cdb_data[k] <= w_slot_data[k];
          r_cdb_tag[k]  <= w_slot_tag[k];
        end
      end
    end
  end

  assign bus.fu_ready    = w_ready;
  assign bus.CDB_valid   = r_cdb_valid;
  assign bus.CDB_Data    = r_cdb_data;
  assign bus.CDB_PRF_idx = r_cdb_tag;

endmodule
